// File: rtl/nasti_burst_reader_if.sv
// NASTI (AXI4) memory channel and AXI4-Stream channel bundles used by the
// burst reader; master modport is the side that issues requests / sources data.
interface nasti_channel #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

interface nasti_stream_channel #(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [DEST_WIDTH-1:0]   t_dest;
  logic [ID_WIDTH-1:0]     t_id;
  logic [USER_WIDTH-1:0]   t_user;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_dest, t_id, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_dest, t_id, t_user,
    output t_ready
  );
endinterface

// File: rtl/nasti_burst_reader.sv
// Reads a byte region over the AXI read channel as 4 KiB-safe INCR bursts
// (one outstanding) and forwards the beats unchanged onto an AXI stream.
module nasti_burst_reader #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [63:0]           cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  done,
  output logic                  err,
  nasti_channel.master          src,
  nasti_stream_channel.master   dest
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [63:0]           beats_left_reg, beats_left_next;
  logic [8:0]            beat_cnt_reg, beat_cnt_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;

  logic [12:0]           to_4k;
  logic [63:0]           burst_wide;
  logic [8:0]            burst;
  logic                  beat_hs;
  logic                  last_beat;

  // Beats left before the next 4 KiB page; a page-aligned address yields a full page.
  assign to_4k = (13'd4096 - {1'b0, cur_addr_reg[11:0]}) >> SHIFT;

  always_comb begin
    burst_wide = beats_left_reg;
    if (burst_wide > 64'(MAX_BURST)) burst_wide = 64'(MAX_BURST);
    if (burst_wide > {51'd0, to_4k}) burst_wide = {51'd0, to_4k};
  end
  assign burst = burst_wide[8:0];

  assign beat_hs   = (state_reg == ST_DATA) && src.r_valid && dest.t_ready;
  assign last_beat = (beat_cnt_reg == 9'd1);

  always_comb begin
    state_next      = state_reg;
    cur_addr_next   = cur_addr_reg;
    beats_left_next = beats_left_reg;
    beat_cnt_next   = beat_cnt_reg;
    done_next       = 1'b0;
    err_next        = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          cur_addr_next   = cmd_addr & ~(ADDR_WIDTH'(BYTES - 1));
          beats_left_next = cmd_len >> SHIFT;
          err_next        = 1'b0;
          if (beats_left_next == 64'd0) done_next = 1'b1;
          else                          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (src.ar_ready) begin
          beat_cnt_next = burst;
          state_next    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_hs) begin
          beat_cnt_next = beat_cnt_reg - 9'd1;
          // Errors are recorded but the transfer runs to completion.
          if ((src.r_resp != 2'b00) || (src.r_last != last_beat)) err_next = 1'b1;
          if (last_beat) begin
            cur_addr_next   = cur_addr_reg + (ADDR_WIDTH'(burst) << SHIFT);
            beats_left_next = beats_left_reg - 64'(burst);
            if (beats_left_next == 64'd0) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = ST_ADDR;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= ST_IDLE;
      cur_addr_reg   <= '0;
      beats_left_reg <= '0;
      beat_cnt_reg   <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_addr_reg   <= cur_addr_next;
      beats_left_reg <= beats_left_next;
      beat_cnt_reg   <= beat_cnt_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

  assign src.ar_valid  = (state_reg == ST_ADDR);
  assign src.ar_addr   = cur_addr_reg;
  assign src.ar_len    = 8'(burst - 9'd1);
  assign src.ar_size   = 3'(SHIFT);
  assign src.ar_burst  = 2'b01;
  assign src.ar_id     = '0;
  assign src.ar_lock   = 1'b0;
  assign src.ar_cache  = 4'd0;
  assign src.ar_prot   = 3'd0;
  assign src.ar_qos    = 4'd0;
  assign src.ar_region = 4'd0;
  assign src.ar_user   = '0;

  assign src.aw_id     = '0;
  assign src.aw_addr   = '0;
  assign src.aw_len    = 8'd0;
  assign src.aw_size   = 3'd0;
  assign src.aw_burst  = 2'b00;
  assign src.aw_lock   = 1'b0;
  assign src.aw_cache  = 4'd0;
  assign src.aw_prot   = 3'd0;
  assign src.aw_qos    = 4'd0;
  assign src.aw_region = 4'd0;
  assign src.aw_user   = '0;
  assign src.aw_valid  = 1'b0;
  assign src.w_data    = '0;
  assign src.w_strb    = '0;
  assign src.w_last    = 1'b0;
  assign src.w_user    = '0;
  assign src.w_valid   = 1'b0;
  assign src.b_ready   = 1'b0;

  // Stream is a pure pass-through of R while a burst is in flight.
  assign src.r_ready    = (state_reg == ST_DATA) && dest.t_ready;
  assign dest.t_valid   = (state_reg == ST_DATA) && src.r_valid;
  assign dest.t_data    = src.r_data;
  assign dest.t_strb    = '1;
  assign dest.t_keep    = '1;
  assign dest.t_last    = (state_reg == ST_DATA) && last_beat &&
                          (beats_left_reg == 64'(burst));
  assign dest.t_dest    = '0;
  assign dest.t_id      = '0;
  assign dest.t_user    = '0;

  logic unused_ok;
  assign unused_ok = ^{src.aw_ready, src.w_ready, src.b_id, src.b_resp,
                       src.b_user, src.b_valid, src.r_id, src.r_user,
                       burst_wide[63:9]};
endmodule

// File: tb/tb_nasti_burst_reader.sv
// Directed bench for nasti_burst_reader: an AXI read slave returns address-tagged
// data, and the stream, AR requests, done/err timing are checked against expectations.
module tb_nasti_burst_reader;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] cmd_addr = '0;
  logic [63:0] cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        done;
  logic        err;

  nasti_channel #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) src ();
  nasti_stream_channel #(.DATA_WIDTH(64)) dest ();

  nasti_burst_reader #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64),
    .MAX_BURST (16)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .done     (done),
    .err      (err),
    .src      (src),
    .dest     (dest)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit          rand_mode = 0;
  bit          r_active = 0;
  logic [63:0] r_addr = '0;
  int          r_rem = 0;
  int          r_sent = 0;
  int          slverr_at = 0;
  int          early_last_at = 0;

  logic [63:0] base = '0;
  logic [63:0] next_ar_addr = '0;
  int          exp_total = 0;
  int          nbeats = 0;
  int          n_ar = 0;
  int          accept_cyc = -1;
  int          last_beat_cyc = -1;
  int          done_cnt = 0;
  int          done_cyc = -1;
  bit          burst_gap_chk = 0;
  bit          ar_pend = 0;
  logic [63:0] ar_pend_addr = '0;
  logic [7:0]  ar_pend_len = '0;
  logic [63:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [63:0] a);
    return {~a[31:0], a[31:0]};
  endfunction

  // One clock: sample at the falling edge, then update the slave just after the rising edge.
  task automatic tick();
    bit          cmd_hs, ar_hs, r_hs;
    logic [63:0] ar_a;
    logic [7:0]  ar_l;
    @(negedge aclk);
    cyc++;
    cmd_hs = cmd_valid && cmd_ready;
    ar_hs  = src.ar_valid && src.ar_ready;
    r_hs   = src.r_valid && src.r_ready;
    ar_a   = src.ar_addr;
    ar_l   = src.ar_len;
    if (cmd_hs) accept_cyc = cyc;
    if (burst_gap_chk) begin
      chk("ar_after_burst", src.ar_valid, 1'b1);
      burst_gap_chk = 0;
    end
    if (accept_cyc >= 0 && cyc == accept_cyc + 1 && exp_total > 0)
      chk("ar_latency", src.ar_valid, 1'b1);
    if (ar_pend)
      chk("ar_stable", {src.ar_valid, src.ar_addr, src.ar_len}, {1'b1, ar_pend_addr, ar_pend_len});
    ar_pend      = src.ar_valid && !src.ar_ready;
    ar_pend_addr = src.ar_addr;
    ar_pend_len  = src.ar_len;
    if (ar_hs) begin
      int off;
      int nb;
      off = int'(src.ar_addr[11:0]);
      nb  = int'(src.ar_len) + 1;
      chk("ar_addr_seq", src.ar_addr, next_ar_addr);
      chk("ar_fields", {src.ar_size, src.ar_burst, src.ar_id}, {3'd3, 2'b01, 1'b0});
      chk("ar_bounds", (off + nb * 8 <= 4096) && (nb <= 16), 1'b1);
      ar_addr_log.push_back(src.ar_addr);
      ar_len_log.push_back(src.ar_len);
      next_ar_addr = next_ar_addr + 64'(nb * 8);
      n_ar++;
    end
    if (r_active) chk("r_t_mirror", {src.r_ready, dest.t_valid}, {dest.t_ready, src.r_valid});
    else          chk("idle_gating", {src.r_ready, dest.t_valid}, 2'b00);
    if (dest.t_valid && dest.t_ready) begin
      chk("t_data", dest.t_data, pat(base + 64'(nbeats) * 64'd8));
      chk("t_last", dest.t_last, nbeats == exp_total - 1);
      chk("t_strb_keep", {dest.t_strb, dest.t_keep}, 16'hFFFF);
      nbeats++;
      if (nbeats == exp_total) last_beat_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge aclk);
    #1;
    if (cmd_hs) cmd_valid = 1'b0;
    if (r_hs) begin
      r_addr = r_addr + 64'd8;
      r_rem--;
      r_sent++;
      if (r_rem == 0) begin
        r_active = 0;
        if (nbeats < exp_total) burst_gap_chk = 1;
      end
    end
    if (ar_hs) begin
      r_active = 1;
      r_addr   = ar_a;
      r_rem    = int'(ar_l) + 1;
    end
    if (r_active) begin
      if (!(src.r_valid && !r_hs)) src.r_valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      src.r_data = pat(r_addr);
      src.r_last = (r_rem == 1) ^ (r_sent + 1 == early_last_at);
      src.r_resp = (r_sent + 1 == slverr_at) ? 2'b10 : 2'b00;
    end else begin
      src.r_valid = 1'b0;
      src.r_last  = 1'b0;
      src.r_resp  = 2'b00;
    end
    dest.t_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    src.ar_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic begin_cmd(input logic [63:0] a, input logic [63:0] l,
                           input logic [63:0] exp_base, input int exp_beats);
    nbeats        = 0;
    n_ar          = 0;
    r_sent        = 0;
    accept_cyc    = -1;
    last_beat_cyc = -1;
    done_cnt      = 0;
    done_cyc      = -1;
    ar_addr_log.delete();
    ar_len_log.delete();
    base         = exp_base;
    next_ar_addr = exp_base;
    exp_total    = exp_beats;
    cmd_addr     = a;
    cmd_len      = l;
    cmd_valid    = 1'b1;
  endtask

  task automatic run_cmd(input string name, input logic [63:0] a, input logic [63:0] l,
                         input logic [63:0] exp_base, input int exp_beats, input int exp_nar,
                         input logic [63:0] ar0_addr, input logic [7:0] ar0_len,
                         input logic [63:0] arl_addr, input logic [7:0] arl_len,
                         input bit exp_err);
    begin_cmd(a, l, exp_base, exp_beats);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
    tick();
    chk({name, ":done_count"}, done_cnt, 1);
    chk({name, ":done_timing"}, done_cyc, (exp_beats == 0 ? accept_cyc : last_beat_cyc) + 1);
    chk({name, ":beats"}, nbeats, exp_beats);
    chk({name, ":n_ar"}, n_ar, exp_nar);
    if (ar_addr_log.size() > 0) begin
      chk({name, ":ar_first"}, {ar_addr_log[0], ar_len_log[0]}, {ar0_addr, ar0_len});
      chk({name, ":ar_last"}, {ar_addr_log[$], ar_len_log[$]}, {arl_addr, arl_len});
    end
    chk({name, ":err"}, err, exp_err);
    chk({name, ":idle_ready"}, cmd_ready, 1'b1);
    $display("cmd %s addr=%h len=%0d beats=%0d ars=%0d err=%0b done_cyc=%0d",
             name, a, l, nbeats, n_ar, err, done_cyc);
  endtask

  initial begin
    src.ar_ready  = 1'b1;
    src.r_valid   = 1'b0;
    src.r_data    = '0;
    src.r_last    = 1'b0;
    src.r_resp    = 2'b00;
    src.r_id      = '0;
    src.r_user    = '0;
    src.aw_ready  = 1'b0;
    src.w_ready   = 1'b0;
    src.b_id      = '0;
    src.b_resp    = 2'b00;
    src.b_user    = '0;
    src.b_valid   = 1'b0;
    dest.t_ready  = 1'b1;

    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", {cmd_ready, done, err, src.ar_valid, src.r_ready, dest.t_valid}, 6'b100000);
    chk("reset_write_idle", {src.aw_valid, src.w_valid, src.b_ready}, 3'b000);
    chk("reset_stream_side", {dest.t_dest, dest.t_id, dest.t_user}, 3'b000);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    run_cmd("single_burst", 64'h1000, 64'd64, 64'h1000, 8, 1, 64'h1000, 8'd7, 64'h1000, 8'd7, 1'b0);
    run_cmd("sixteen_bursts", 64'h2000, 64'd2048, 64'h2000, 256, 16, 64'h2000, 8'd15, 64'h2780, 8'd15, 1'b0);
    run_cmd("split_4k", 64'h0FC0, 64'd128, 64'h0FC0, 16, 2, 64'h0FC0, 8'd7, 64'h1000, 8'd7, 1'b0);
    run_cmd("zero_len", 64'h3000, 64'd0, 64'h3000, 0, 0, 64'h0, 8'd0, 64'h0, 8'd0, 1'b0);
    run_cmd("len13", 64'h3000, 64'd13, 64'h3000, 1, 1, 64'h3000, 8'd0, 64'h3000, 8'd0, 1'b0);
    run_cmd("unaligned", 64'h1007, 64'd16, 64'h1000, 2, 1, 64'h1000, 8'd1, 64'h1000, 8'd1, 1'b0);

    rand_mode = 1;
    run_cmd("backpressure", 64'h4000, 64'd200, 64'h4000, 25, 2, 64'h4000, 8'd15, 64'h4080, 8'd8, 1'b0);
    rand_mode    = 0;
    dest.t_ready = 1'b1;
    src.ar_ready = 1'b1;

    slverr_at = 3;
    run_cmd("slverr_beat3", 64'h5000, 64'd64, 64'h5000, 8, 1, 64'h5000, 8'd7, 64'h5000, 8'd7, 1'b1);
    slverr_at = 0;
    run_cmd("err_cleared", 64'h5100, 64'd32, 64'h5100, 4, 1, 64'h5100, 8'd3, 64'h5100, 8'd3, 1'b0);
    early_last_at = 2;
    run_cmd("early_rlast", 64'h6000, 64'd64, 64'h6000, 8, 1, 64'h6000, 8'd7, 64'h6000, 8'd7, 1'b1);
    early_last_at = 0;

    // Abandon a burst in flight with an asynchronous reset.
    begin_cmd(64'h7000, 64'd256, 64'h7000, 32);
    for (int i = 0; i < 500 && nbeats < 5; i++) tick();
    chk("pre_reset_progress", nbeats >= 5, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_reset_outputs", {cmd_ready, done, err, src.ar_valid, src.r_ready, dest.t_valid}, 6'b100000);
    $display("cmd mid_op_reset addr=%h beats_before_reset=%0d", 64'h7000, nbeats);
    r_active      = 0;
    src.r_valid   = 1'b0;
    ar_pend       = 0;
    burst_gap_chk = 0;
    exp_total     = 0;
    accept_cyc    = -1;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    run_cmd("post_reset", 64'h1000, 64'd64, 64'h1000, 8, 1, 64'h1000, 8'd7, 64'h1000, 8'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
